// File: rtl/logic_unit_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// Optional parity wire present when LOGIC_UNIT_PARITY_EN is defined.
interface logic_unit_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             acc_mode;
   logic             acc_clr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [CNT_W-1:0] op_count;
`ifdef LOGIC_UNIT_PARITY_EN
   logic             parity;

   modport master (
      output in_valid, a, b, op, acc_mode, acc_clr, out_ready,
      input  in_ready, out_valid, result, op_count, parity
   );
   modport slave (
      input  in_valid, a, b, op, acc_mode, acc_clr, out_ready,
      output in_ready, out_valid, result, op_count, parity
   );
`else
   modport master (
      output in_valid, a, b, op, acc_mode, acc_clr, out_ready,
      input  in_ready, out_valid, result, op_count
   );
   modport slave (
      input  in_valid, a, b, op, acc_mode, acc_clr, out_ready,
      output in_ready, out_valid, result, op_count
   );
`endif
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshake, accumulator and beat counter.
// Define LOGIC_UNIT_PARITY_EN to add a registered parity output alongside result.
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input logic         clk,
   input logic         rst_n,
   input logic         ena,
   logic_unit_if.slave bus
);

   function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      r = '0;
      case (op)
         3'b000: r = a & b;
         3'b001: r = a | b;
         3'b010: r = a ^ b;
         3'b011: r = ~(a & b);
         3'b100: r = ~(a | b);
         3'b101: r = ~(a ^ b);
         3'b110: r = a;
         3'b111: r = ~a;
         default: r = '0;
      endcase
      return r;
   endfunction

   logic [WIDTH-1:0] result_p1;
   logic             vld_p1;
   logic [WIDTH-1:0] acc_p1;
   logic [CNT_W-1:0] cnt_p1;
   logic             in_ready;
   logic             accept;
   logic [WIDTH-1:0] b_sel;
   logic [WIDTH-1:0] op_res;

   // rst_n term keeps in_ready low during reset even if out_ready is high.
   assign in_ready = rst_n & ena & (~vld_p1 | bus.out_ready);
   assign accept   = bus.in_valid & in_ready;
   assign b_sel    = bus.acc_mode ? acc_p1 : bus.b;
   assign op_res   = logic_op(bus.op, bus.a, b_sel);

   // Stage p0 -> p1: single result register; accept overrides drain in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_p1 <= '0;
         vld_p1    <= 1'b0;
         acc_p1    <= '0;
         cnt_p1    <= '0;
      end else if (ena) begin
         if (accept) begin
            result_p1 <= op_res;
            vld_p1    <= 1'b1;
            cnt_p1    <= cnt_p1 + CNT_W'(1);
         end else if (vld_p1 && bus.out_ready) begin
            vld_p1 <= 1'b0;
         end
         if (bus.acc_clr) begin
            acc_p1 <= '0;
         end else if (accept && bus.acc_mode) begin
            acc_p1 <= op_res;
         end
      end
   end

`ifdef LOGIC_UNIT_PARITY_EN
   logic par_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_p1 <= 1'b0;
      end else if (ena && accept) begin
         par_p1 <= ^op_res;
      end
   end

   assign bus.parity = par_p1;
`endif

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = vld_p1;
   assign bus.result    = result_p1;
   assign bus.op_count  = cnt_p1;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (WIDTH=8, CNT_W=4).
module tb_logic_unit_pipe;

   logic clk;
   logic rst_n;
   logic ena;
   int   n_tests;
   int   n_fail;

   logic_unit_if #(.WIDTH(8), .CNT_W(4)) bus ();

   logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] op_exp [8];
      op_exp = '{8'h42, 8'hDB, 8'h99, 8'hBD, 8'h24, 8'h66, 8'hC3, 8'h3C};
      n_tests = 0;
      n_fail  = 0;
      rst_n = 1'b0;
      ena   = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.op        = '0;
      bus.acc_mode  = 1'b0;
      bus.acc_clr   = 1'b0;
      bus.out_ready = 1'b1;

      tick();
      tick();
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_result", 32'(bus.result), 0);
      chk("rst_op_count", 32'(bus.op_count), 0);
      rst_n = 1'b1;
      #1;
      chk("idle_in_ready", 32'(bus.in_ready), 1);

      // All eight ops on a fixed operand pair.
      bus.in_valid = 1'b1;
      bus.a = 8'hC3;
      bus.b = 8'h5A;
      for (int i = 0; i < 8; i++) begin
         bus.op = 3'(i);
         tick();
         chk($sformatf("op%0d_result", i), 32'(bus.result), 32'(op_exp[i]));
         chk($sformatf("op%0d_valid", i), 32'(bus.out_valid), 1);
         chk($sformatf("op%0d_count", i), 32'(bus.op_count), 32'(i + 1));
      end

      // Back-pressure.
      bus.a = 8'hFF;
      bus.b = 8'h0F;
      bus.op = 3'b000;
      tick();
      chk("bp_first", 32'(bus.result), 32'h0F);
      chk("bp_first_count", 32'(bus.op_count), 9);
      bus.out_ready = 1'b0;
      bus.a = 8'hAA;
      bus.op = 3'b110;
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("bp_hold_result%0d", i), 32'(bus.result), 32'h0F);
         chk($sformatf("bp_hold_valid%0d", i), 32'(bus.out_valid), 1);
         chk($sformatf("bp_hold_ready%0d", i), 32'(bus.in_ready), 0);
         chk($sformatf("bp_hold_count%0d", i), 32'(bus.op_count), 9);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(bus.in_ready), 1);
      tick();
      chk("bp_release_result", 32'(bus.result), 32'hAA);
      chk("bp_release_count", 32'(bus.op_count), 10);

      // Accumulate with XOR.
      bus.in_valid = 1'b0;
      bus.acc_clr = 1'b1;
      tick();
      chk("drain_valid", 32'(bus.out_valid), 0);
      chk("drain_result_hold", 32'(bus.result), 32'hAA);
      bus.acc_clr = 1'b0;
      bus.in_valid = 1'b1;
      bus.acc_mode = 1'b1;
      bus.op = 3'b010;
      bus.b = 8'hF0;
      bus.a = 8'h01;
      tick();
      chk("acc_1", 32'(bus.result), 32'h01);
      bus.a = 8'h02;
      tick();
      chk("acc_2", 32'(bus.result), 32'h03);
`ifdef LOGIC_UNIT_PARITY_EN
      chk("parity_03", 32'(bus.parity), 0);
`endif
      bus.a = 8'h04;
      tick();
      chk("acc_3", 32'(bus.result), 32'h07);
`ifdef LOGIC_UNIT_PARITY_EN
      chk("parity_07", 32'(bus.parity), 1);
`endif
      bus.a = 8'h08;
      bus.acc_clr = 1'b1;
      tick();
      chk("acc_clr_beat", 32'(bus.result), 32'h0F);
      bus.acc_clr = 1'b0;
      bus.a = 8'h10;
      tick();
      chk("acc_after_clr", 32'(bus.result), 32'h10);
      chk("acc_count", 32'(bus.op_count), 15);
      bus.acc_mode = 1'b0;

      // 16th beat wraps the 4-bit counter.
      bus.a = 8'h55;
      bus.op = 3'b110;
      tick();
      chk("wrap_16_count", 32'(bus.op_count), 0);
      chk("wrap_16_result", 32'(bus.result), 32'h55);

      // ena low: frozen, and a pending drain is not consumed.
      ena = 1'b0;
      bus.a = 8'h66;
      #1;
      chk("ena0_in_ready", 32'(bus.in_ready), 0);
      tick();
      tick();
      chk("ena0_valid", 32'(bus.out_valid), 1);
      chk("ena0_result", 32'(bus.result), 32'h55);
      chk("ena0_count", 32'(bus.op_count), 0);

      // Asynchronous reset in the middle of a stall.
      ena = 1'b1;
      bus.out_ready = 1'b0;
      bus.a = 8'h77;
      tick();
      chk("stall_result", 32'(bus.result), 32'h55);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(bus.out_valid), 0);
      chk("async_rst_result", 32'(bus.result), 0);
      chk("async_rst_count", 32'(bus.op_count), 0);
      chk("async_rst_in_ready", 32'(bus.in_ready), 0);
      tick();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;

      // Accumulator was 0x10 before reset; OR with a=0 exposes it.
      bus.acc_mode = 1'b1;
      bus.op = 3'b001;
      bus.a = 8'h00;
      tick();
      chk("async_rst_acc", 32'(bus.result), 0);
      chk("post_rst_count", 32'(bus.op_count), 1);
      bus.acc_mode = 1'b0;
      bus.op = 3'b000;
      for (int i = 0; i < 15; i++) tick();
      chk("wrap16_count", 32'(bus.op_count), 0);
      tick();
      chk("wrap17_count", 32'(bus.op_count), 1);
      bus.in_valid = 1'b0;
      tick();
      chk("final_drain", 32'(bus.out_valid), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered bitwise logic unit; next generation of the team's AND/OR selector tile.
- Adds eight selectable logic ops, a valid/ready handshake with back-pressure, and an accumulate mode that feeds the last result back as operand B.
- Also adds a transaction counter.
- Sits between a Tiny Tapeout-style pin wrapper and downstream logic; one result register stage.

Parameters:
- WIDTH, 8, operand/result width in bits (1..32).
- CNT_W, 8, width of the accepted-transaction counter (1..16).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  global enable; low freezes all state.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit can accept a beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B. Ignored in accumulate mode.
- op  in  3  operation select.
- acc_mode  in  1  1 = use accumulator as operand B.
- acc_clr  in  1  synchronous clear of accumulator.
- out_valid  out  1  result register holds unconsumed data.
- out_ready  in  1  downstream accepts result.
- result  out  WIDTH  registered result.
- op_count  out  CNT_W  number of accepted beats, wraps.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, result=0, acc=0, op_count=0. in_ready is combinational and is 0 while rst_n is low.
- Op encoding: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 pass A, 111 NOT A. All ops are bitwise over WIDTH.
- Operand B (Bsel) = acc when acc_mode=1, else b. acc_mode is sampled with the beat.
- in_ready = ena & (~out_valid | out_ready). This is a single-register pipeline with pass-through back-pressure.
- Accept: in_valid & in_ready at a rising edge. On accept:
  - result <= f(op, a, Bsel), out_valid <= 1.
  - op_count <= op_count+1, wrapping modulo 2^CNT_W with no flag.
  - acc <= new result, only if acc_mode=1.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 beat/cycle while out_ready=1.
- Drain: out_valid & out_ready with no accept in the same cycle -> out_valid <= 0. result holds its last value; it is not cleared.
- Simultaneous drain and accept: out_valid stays 1 and result takes the new value.
- Stall: out_valid=1 & out_ready=0 -> result, out_valid and acc hold; in_ready=0.
- acc_clr (effective only when ena=1) has priority over the accumulator update. The beat in the same cycle still uses the old acc as Bsel; acc becomes 0 afterwards. acc_clr does not touch result, out_valid or op_count.
- ena=0: no register changes and in_ready=0. out_valid and result remain visible. A downstream drain while ena=0 is not consumed; out_valid holds until ena returns.
- Asynchronous reset mid-transfer discards any in-flight result and clears all state immediately.
- Operand/op values with in_valid=0 are don't-care and have no effect.
- No X propagation: op is fully decoded; no default-to-X.

Optional Feature:
- Macro LOGIC_UNIT_PARITY_EN.
- Defined: extra output port parity (out, 1) = XOR-reduction of result, registered with result. Reset value 0. It follows the same hold/update rules as result.
- Undefined: the port does not exist and no parity logic is built.

Test Plan:
- Reset then ops, WIDTH=8, out_ready=1:
  - a=0xC3, b=0x5A, op=000 -> result=0x42 one cycle after accept, out_valid=1, op_count=1.
  - Then op=001 -> 0xDB; 010 -> 0x99; 011 -> 0xBD; 100 -> 0x24; 101 -> 0x66; 110 -> 0xC3; 111 -> 0x3C. op_count=8.
- Back-pressure:
  - Accept a=0xFF, b=0x0F, op=000 -> result=0x0F. Then hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result stays 0x0F, op_count unchanged.
  - Raise out_ready -> next beat accepted that same cycle; result updates one cycle later.
- Accumulate:
  - acc_clr pulse, then acc_mode=1, op=010, a=0x01,0x02,0x04 back-to-back -> results 0x01, 0x03, 0x07.
  - acc_clr asserted together with a=0x08 -> result=0x0F, then acc=0. Next a=0x10 -> result=0x10.
- Counter wrap, CNT_W=4: 17 accepted beats -> op_count=1. 16 beats -> 0.
- ena/reset:
  - ena=0 with in_valid=1 -> no accept, state frozen.
  - Assert rst_n=0 mid-stall -> out_valid, result, acc and op_count all 0 immediately, before the next clock edge.
- With LOGIC_UNIT_PARITY_EN: result=0x07 -> parity=1; result=0x03 -> parity=0.
